// File: rtl/regfile_wb_writer_if.sv
// Producer channels A (ALU) and B (load unit) plus the register file write port.
// slave = the write-back writer, master = producers / register file side.
interface regfile_wb_writer_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;

    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;

    logic            wen;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dataRd;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  wen, rd, dataRd
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output wen, rd, dataRd
    );
endinterface

// File: rtl/regfile_wb_writer.sv
// Write-back writer: two producer FIFOs, round-robin onto the register file write port, busy scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN hides the busy bit of the register being written this cycle.
module regfile_wb_writer #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    regfile_wb_writer_if.slave  wb,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic [AW-1:0]       q_rs1_i,
    input  logic [AW-1:0]       q_rs2_i,
    output logic                busy1_o,
    output logic                busy2_o
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam int            NREG = 1 << AW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [0:0]    RR_A = 1'b0;
    localparam logic [0:0]    RR_B = 1'b1;

    logic [AW-1:0]   aRd_q   [DEPTH];
    logic [XLEN-1:0] aData_q [DEPTH];
    logic [PW-1:0]   aWptr_q, aRptr_q;
    logic [CW-1:0]   aCnt_q, aCnt_d;

    logic [AW-1:0]   bRd_q   [DEPTH];
    logic [XLEN-1:0] bData_q [DEPTH];
    logic [PW-1:0]   bWptr_q, bRptr_q;
    logic [CW-1:0]   bCnt_q, bCnt_d;

    logic [0:0]      rr_q, rr_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] dataRd_q, dataRd_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            aPush, bPush, aEmpty, bEmpty;
    logic            popA, popB, pop;
    logic [AW-1:0]   popRd;
    logic [XLEN-1:0] popData;

    // Ready comes from registered occupancy only, never from valid.
    assign wb.a_ready = (aCnt_q != FULL);
    assign wb.b_ready = (bCnt_q != FULL);
    assign aPush      = wb.a_valid && wb.a_ready;
    assign bPush      = wb.b_valid && wb.b_ready;
    assign aEmpty     = (aCnt_q == '0);
    assign bEmpty     = (bCnt_q == '0);

    assign popA    = !aEmpty && (bEmpty || rr_q == RR_A);
    assign popB    = !bEmpty && !popA;
    assign pop     = popA || popB;
    assign popRd   = popA ? aRd_q[aRptr_q]   : bRd_q[bRptr_q];
    assign popData = popA ? aData_q[aRptr_q] : bData_q[bRptr_q];

    assign aCnt_d = aCnt_q + CW'(aPush) - CW'(popA);
    assign bCnt_d = bCnt_q + CW'(bPush) - CW'(popB);

    // The pointer only moves when both channels competed; a lone channel does not steal the turn.
    always_comb begin
        rr_d = rr_q;
        if (!aEmpty && !bEmpty) begin
            rr_d = popA ? RR_B : RR_A;
        end
    end

    always_comb begin
        wen_d    = pop && (popRd != '0);
        rd_d     = pop ? popRd   : rd_q;
        dataRd_d = pop ? popData : dataRd_q;
    end

    // Clear follows the visible write; a same-edge issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (aPush) begin
            aRd_q[aWptr_q]   <= wb.a_rd;
            aData_q[aWptr_q] <= wb.a_data;
        end
        if (bPush) begin
            bRd_q[bWptr_q]   <= wb.b_rd;
            bData_q[bWptr_q] <= wb.b_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aWptr_q  <= '0;
            aRptr_q  <= '0;
            aCnt_q   <= '0;
            bWptr_q  <= '0;
            bRptr_q  <= '0;
            bCnt_q   <= '0;
            rr_q     <= RR_A;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            dataRd_q <= '0;
            busy_q   <= '0;
        end else begin
            if (aPush) aWptr_q <= aWptr_q + PW'(1);
            if (popA)  aRptr_q <= aRptr_q + PW'(1);
            if (bPush) bWptr_q <= bWptr_q + PW'(1);
            if (popB)  bRptr_q <= bRptr_q + PW'(1);
            aCnt_q   <= aCnt_d;
            bCnt_q   <= bCnt_d;
            rr_q     <= rr_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            dataRd_q <= dataRd_d;
            busy_q   <= busy_d;
        end
    end

    assign wb.wen    = wen_q;
    assign wb.rd     = rd_q;
    assign wb.dataRd = dataRd_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign busy1_o = busy_q[q_rs1_i] && !(wen_q && (rd_q == q_rs1_i));
    assign busy2_o = busy_q[q_rs2_i] && !(wen_q && (rd_q == q_rs2_i));
`else
    assign busy1_o = busy_q[q_rs1_i];
    assign busy2_o = busy_q[q_rs2_i];
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Bench for regfile_wb_writer: queue-level reference model compared every cycle, plus literal checks.
module tb_regfile_wb_writer;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] q_rs1;
    logic [AW-1:0] q_rs2;
    logic          busy1;
    logic          busy2;

    regfile_wb_writer_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_writer #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb          (bus),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .q_rs1_i     (q_rs1),
        .q_rs2_i     (q_rs2),
        .busy1_o     (busy1),
        .busy2_o     (busy2)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    int cyc  = 0;

    ent_t            qa[$];
    ent_t            qb[$];
    bit              rrB   = 1'b0;
    bit              mWen  = 1'b0;
    logic [AW-1:0]   mRd   = '0;
    logic [XLEN-1:0] mData = '0;
    bit [31:0]       mBusy = '0;

    ent_t mEnt;
    bit   mPop, mAccA, mAccB, mBoth;

    logic [AW-1:0]   logRd[$];
    logic [XLEN-1:0] logData[$];
    int              logCyc[$];
    bit              sawAFull = 1'b0;

    int exp3[6] = '{1, 9, 2, 10, 3, 11};
    int nA, nB;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: two queues, a turn bit, one write register and a busy array.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            rrB   = 1'b0;
            mWen  = 1'b0;
            mRd   = '0;
            mData = '0;
            mBusy = '0;
        end else begin
            mAccA = bus.a_valid && (qa.size() < DEPTH);
            mAccB = bus.b_valid && (qb.size() < DEPTH);
            mBoth = (qa.size() != 0) && (qb.size() != 0);
            mPop  = 1'b0;
            if (qa.size() != 0 && (qb.size() == 0 || !rrB)) begin
                mEnt = qa.pop_front();
                mPop = 1'b1;
                if (mBoth) rrB = 1'b1;
            end else if (qb.size() != 0) begin
                mEnt = qb.pop_front();
                mPop = 1'b1;
                if (mBoth) rrB = 1'b0;
            end
            if (mWen) mBusy[mRd] = 1'b0;
            if (iss_valid && iss_rd != 0) mBusy[iss_rd] = 1'b1;
            mWen = mPop && (mEnt.rd != 0);
            if (mPop) begin
                mRd   = mEnt.rd;
                mData = mEnt.data;
            end
            if (mAccA) qa.push_back('{rd: bus.a_rd, data: bus.a_data});
            if (mAccB) qb.push_back('{rd: bus.b_rd, data: bus.b_data});
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("wen",     32'(bus.wen),     32'(mWen));
            checkOutput("rd",      32'(bus.rd),      32'(mRd));
            checkOutput("dataRd",  bus.dataRd,       mData);
            checkOutput("a_ready", 32'(bus.a_ready), 32'(qa.size() < DEPTH));
            checkOutput("b_ready", 32'(bus.b_ready), 32'(qb.size() < DEPTH));
            checkOutput("busy1", 32'(busy1), 32'(mBusy[q_rs1] && !(BYP && mWen && mRd == q_rs1)));
            checkOutput("busy2", 32'(busy2), 32'(mBusy[q_rs2] && !(BYP && mWen && mRd == q_rs2)));
            if (bus.wen) begin
                logRd.push_back(bus.rd);
                logData.push_back(bus.dataRd);
                logCyc.push_back(cyc);
            end
            if (bus.a_valid && !bus.a_ready) sawAFull = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        logRd.delete();
        logData.delete();
        logCyc.delete();
    endtask

    // Offers one entry on channel ch (0=A, 1=B) and holds it until accepted.
    task automatic applyStimulus(input bit ch, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        int  n = 0;
        bit  took = 1'b0;
        if (ch == 1'b0) begin
            bus.a_valid = 1'b1; bus.a_rd = r; bus.a_data = d;
        end else begin
            bus.b_valid = 1'b1; bus.b_rd = r; bus.b_data = d;
        end
        do begin
            took = (ch == 1'b0) ? bus.a_ready : bus.b_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 50);
        if (!took) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL accept_timeout ch=%0d actual=not_accepted expected=accepted", ch);
        end
        if (ch == 1'b0) bus.a_valid = 1'b0;
        else            bus.b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        q_rs1     = 5'd1;
        q_rs2     = 5'd31;
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] reset and idle");
        checkOutput("idle_wen",     32'(bus.wen),     32'd0);
        checkOutput("idle_rd",      32'(bus.rd),      32'd0);
        checkOutput("idle_dataRd",  bus.dataRd,       32'd0);
        checkOutput("idle_a_ready", 32'(bus.a_ready), 32'd1);
        checkOutput("idle_b_ready", 32'(bus.b_ready), 32'd1);
        checkOutput("idle_busy1",   32'(busy1),       32'd0);
        checkOutput("idle_busy2",   32'(busy2),       32'd0);

        $display("[TB] issue then single write, latency");
        iss_valid = 1'b1; iss_rd = 5'd5; q_rs1 = 5'd5;
        tick(1);
        iss_valid = 1'b0;
        checkOutput("busy5_issued", 32'(busy1), 32'd1);
        applyStimulus(1'b0, 5'd5, 32'hDEADBEEF);
        checkOutput("lat_wen_early", 32'(bus.wen), 32'd0);
        tick(1);
        checkOutput("lat_wen",    32'(bus.wen), 32'd1);
        checkOutput("lat_rd",     32'(bus.rd),  32'd5);
        checkOutput("lat_dataRd", bus.dataRd,   32'hDEADBEEF);
        checkOutput("busy5_during_write", 32'(busy1), BYP ? 32'd0 : 32'd1);
        tick(1);
        checkOutput("busy5_after_write", 32'(busy1), 32'd0);
        checkOutput("wen_after_write",   32'(bus.wen), 32'd0);

        $display("[TB] round-robin interleave");
        clearLog();
        fork
            for (int i = 1; i <= 3; i++) applyStimulus(1'b0, AW'(i),     32'h100 + 32'(i));
            for (int i = 9; i <= 11; i++) applyStimulus(1'b1, AW'(i),    32'h900 + 32'(i));
        join
        tick(6);
        checkOutput("rr_count", 32'(logRd.size()), 32'd6);
        if (logRd.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput($sformatf("rr_order%0d", i), 32'(logRd[i]), 32'(exp3[i]));
                checkOutput($sformatf("rr_cycle%0d", i), 32'(logCyc[i]), 32'(logCyc[0] + i));
            end
        end

        $display("[TB] channel A back-pressure");
        clearLog();
        sawAFull = 1'b0;
        fork
            for (int i = 0; i < 4; i++) applyStimulus(1'b0, AW'(12 + i), 32'hA000 + 32'(i));
            for (int i = 0; i < 6; i++) applyStimulus(1'b1, AW'(20 + i), 32'hB000 + 32'(i));
        join
        tick(10);
        checkOutput("a_full_seen", 32'(sawAFull), 32'd1);
        checkOutput("bp_count",    32'(logRd.size()), 32'd10);
        nA = 0;
        nB = 0;
        for (int i = 0; i < logRd.size(); i++) begin
            if (logRd[i] >= 12 && logRd[i] <= 15) begin
                checkOutput($sformatf("bp_a%0d", nA), logData[i], 32'hA000 + 32'(nA));
                nA++;
            end else begin
                checkOutput($sformatf("bp_b%0d", nB), logData[i], 32'hB000 + 32'(nB));
                nB++;
            end
        end
        checkOutput("bp_a_total", 32'(nA), 32'd4);
        checkOutput("bp_b_total", 32'(nB), 32'd6);

        $display("[TB] register x0");
        clearLog();
        applyStimulus(1'b0, 5'd0, 32'h1234);
        tick(3);
        checkOutput("x0_no_write", 32'(logRd.size()), 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0;
        tick(1);
        iss_valid = 1'b0;
        tick(1);
        checkOutput("x0_not_busy", 32'(busy1), 32'd0);

        $display("[TB] set beats clear, then mid-stream reset");
        q_rs1 = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick(1);
        iss_valid = 1'b0;
        applyStimulus(1'b0, 5'd7, 32'h77);
        tick(1);
        checkOutput("r7_wen", 32'(bus.wen), 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick(1);
        iss_valid = 1'b0;
        checkOutput("r7_set_wins", 32'(busy1), 32'd1);
        tick(2);
        checkOutput("r7_still_busy", 32'(busy1), 32'd1);

        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h33;
        bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h44;
        tick(1);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wen",     32'(bus.wen),     32'd0);
        checkOutput("rst_rd",      32'(bus.rd),      32'd0);
        checkOutput("rst_dataRd",  bus.dataRd,       32'd0);
        checkOutput("rst_a_ready", 32'(bus.a_ready), 32'd1);
        checkOutput("rst_b_ready", 32'(bus.b_ready), 32'd1);
        checkOutput("rst_busy7",   32'(busy1),       32'd0);
        clearLog();
        tick(1);
        rst_n = 1'b1;
        tick(4);
        checkOutput("rst_dropped", 32'(logRd.size()), 32'd0);
        checkOutput("rst_busy7_after", 32'(busy1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
